// File: rtl/user_input_if.sv
`default_nettype none
// ============================================================================
// Module  : user_input_if
// Brief   : Level-in / pulse-out bundle between a slow signal source and its
//           edge-pulse generator.
// Revision: 1.0
// ============================================================================
interface user_input_if;
    logic in;
    logic out;

    modport master (output in, input out);
    modport slave  (input in, output out);
endinterface
`default_nettype wire

// File: rtl/user_input.sv
`default_nettype none
// ============================================================================
// Module  : user_input
// Brief   : Synchronizes a slow or asynchronous level, optionally debounces
//           it, and emits a one-cycle pulse on each accepted rising edge.
// Revision: 1.0
// ============================================================================
module user_input #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  wire logic    clk,
    input  wire logic    reset,
    user_input_if.slave  bus
);

    localparam int C_CNT_W = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   lvl_q, lvl_d;
    logic                   lvl_dly_q, lvl_dly_d;
    logic                   out_q, out_d;
    logic                   w_sync;

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = bus.in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign w_sync = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            always_comb lvl_d = w_sync;
        end else begin : g_filter
            logic [C_CNT_W-1:0] cnt_q, cnt_d;

            // The level is taken over on the D-th consecutive cycle that it disagrees.
            always_comb begin
                lvl_d = lvl_q;
                cnt_d = cnt_q;
                if (w_sync == lvl_q) begin
                    cnt_d = '0;
                end else if (cnt_q == C_CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    lvl_d = w_sync;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + C_CNT_W'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    always_comb begin
        lvl_dly_d = lvl_q;
        out_d     = lvl_q & ~lvl_dly_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q    <= '0;
            lvl_q     <= 1'b0;
            lvl_dly_q <= 1'b0;
            out_q     <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            lvl_q     <= lvl_d;
            lvl_dly_q <= lvl_dly_d;
            out_q     <= out_d;
        end
    end

    assign bus.out = out_q;

endmodule
`default_nettype wire

// File: tb/tb_user_input.sv
`default_nettype none
// ============================================================================
// Module  : tb_user_input
// Brief   : Directed bench driving an undebounced and a D=4 instance in parallel.
// Revision: 1.0
// ============================================================================
module tb_user_input;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;
    int   pc0;
    int   pc4;

    user_input_if bus0 ();
    user_input_if bus4 ();

    user_input #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(0)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    user_input #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs, let one rising edge pass, then check both outputs.
    task automatic cyc(input logic iv, input logic rv, input logic e0, input logic e4,
                       input string tag);
        bus0.in = iv;
        bus4.in = iv;
        reset   = rv;
        @(posedge clk);
        #1;
        chk({tag, "_d0"}, int'(bus0.out), int'(e0));
        chk({tag, "_d4"}, int'(bus4.out), int'(e4));
        pc0 += int'(bus0.out);
        pc4 += int'(bus4.out);
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        pc0     = 0;
        pc4     = 0;
        reset   = 1'b1;
        bus0.in = 1'b0;
        bus4.in = 1'b0;

        for (int c = 0; c < 3; c++) cyc(1'b0, 1'b1, 1'b0, 1'b0, "reset");
        for (int c = 0; c < 10; c++) cyc(1'b0, 1'b0, 1'b0, 1'b0, "idle");

        // First sample at edge 0: D=0 pulses after edge 3; the filter adds D-1 more edges.
        for (int c = 0; c < 20; c++) cyc(1'b1, 1'b0, c == 3, c == 6, "rise");
        for (int c = 0; c < 15; c++) cyc(1'b0, 1'b0, 1'b0, 1'b0, "fall");

        pc0 = 0;
        pc4 = 0;
        for (int c = 0; c < 128; c++)
            cyc((c % 16) < 8, 1'b0, (c % 16) == 3, (c % 16) == 6, "square");
        chk("square_cnt_d0", pc0, 8);
        chk("square_cnt_d4", pc4, 8);

        for (int c = 0; c < 18; c++) cyc(c < 3, 1'b0, c == 3, 1'b0, "glitch");

        for (int c = 0; c < 4; c++) cyc(1'b1, 1'b1, 1'b0, 1'b0, "hold_rst");
        pc0 = 0;
        pc4 = 0;
        for (int c = 0; c < 20; c++) cyc(1'b1, 1'b0, c == 3, c == 6, "hold_rel");
        chk("hold_cnt_d0", pc0, 1);
        chk("hold_cnt_d4", pc4, 1);

        for (int c = 0; c < 15; c++) cyc(1'b0, 1'b0, 1'b0, 1'b0, "settle");
        for (int c = 0; c < 4; c++) cyc(1'b1, 1'b0, c == 3, 1'b0, "pre_rst");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, "mid_rst");
        pc0 = 0;
        pc4 = 0;
        for (int c = 0; c < 20; c++) cyc(1'b1, 1'b0, c == 3, c == 6, "post_rst");
        chk("post_cnt_d0", pc0, 1);
        chk("post_cnt_d4", pc4, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
